rat_intr_ctrl: RTL and testbench
================================

// Module: rat_intr_ctrl
// PURPOSE
//  Interrupt controller between RAT_MCU and the wrapper's peripheral sources; drives the MCU INTV input.
//  Synchronizes and edge-detects up to 8 IRQ lines, latches them as pending, and gates them with a mask.
//  Sequences the INTV pulse so the 50 MHz MCU samples it reliably.
//  Mask, status and clear registers live on the MCU port bus (PORT_ID/OUT_PORT/IO_STRB); readback joins the wrapper input mux.
// PARAMETERS
//  NUM_SRC       8      number of IRQ sources, legal range 1..8
//  INTV_HOLD     2      CLK cycles INTV stays high per assertion, 1..15
//  REARM_CYCLES  1024   CLK cycles in WAIT before re-asserting INTV; 0 disables re-arm
//  MASK_ID       8'h80  port ID of the R/W mask register
//  STATUS_ID     8'h81  port ID of the RO pending register
//  CLEAR_ID      8'h82  port ID of the W1C pending clear
//  VECTOR_ID     8'h83  port ID of the RO vector register (macro-dependent)
// PORTS
//  CLK       in   1        100 MHz system clock
//  RESET_N   in   1        asynchronous active-low reset
//  IRQ       in   NUM_SRC  raw interrupt requests, level, may be asynchronous
//  PORT_ID   in   8        MCU port ID
//  OUT_PORT  in   8        MCU write data
//  IO_STRB   in   1        MCU write strobe, sampled on posedge CLK
//  RD_DATA   out  8        readback data, zero-extended above NUM_SRC
//  RD_HIT    out  1        1 when PORT_ID selects a readable register (combinational)
//  INTV      out  1        interrupt request to RAT_MCU, registered
// BEHAVIOUR
//  Reset (async on RESET_N=0):
//   - mask, pending, synchronizer and edge flops, and counters all clear to 0.
//   - State goes to IDLE; INTV drops to 0 immediately.
//   - Reset mid-assertion aborts the pulse; no interrupt is remembered.
//  IRQ path:
//   - 2-flop synchronizer, then rising-edge detect, so the first pending set is 3 CLK after the IRQ edge.
//   - A rising edge sets pending[i] regardless of mask.
//  Writes (posedge CLK, IO_STRB=1):
//   - PORT_ID==MASK_ID: mask <= OUT_PORT[NUM_SRC-1:0].
//   - PORT_ID==CLEAR_ID: pending &= ~OUT_PORT[NUM_SRC-1:0].
//   - A set and a clear of the same bit in the same cycle: the set wins, so the bit stays 1.
//   - Writes to other IDs are ignored.
//  Reads (combinational):
//   - MASK_ID returns mask; STATUS_ID returns pending.
//   - Any other ID: RD_DATA=0 and RD_HIT=0.
//  active = |(pending & mask)
//  State machine:
//   - IDLE: INTV=0. Goes to ASSERT on the next posedge when active=1.
//   - ASSERT: INTV=1 for exactly INTV_HOLD cycles, then goes to WAIT.
//   - WAIT: INTV=0.
//     - Goes to IDLE on the cycle active=0.
//     - If REARM_CYCLES!=0 and active stays 1 for REARM_CYCLES cycles, goes back to ASSERT.
//     - The re-arm counter restarts on every entry to WAIT.
//   - Masking all sources in ASSERT does not shorten the pulse.
//   - Masking all sources in WAIT sends the FSM to IDLE next cycle.
//  Latency: IRQ edge to INTV=1 is 4 CLK.
//  A new source arriving during ASSERT/WAIT produces no extra pulse. Software must service pending before returning.
// CONFIGURATION
//  RAT_INTR_VECTOR_ID_EN defined:
//   - A read of VECTOR_ID returns {1'b1, 4'b0, idx[2:0]}.
//   - idx is the lowest-numbered bit set in (pending & mask).
//   - If no bit is set, the read returns 8'h00. RD_HIT=1 for VECTOR_ID.
//  RAT_INTR_VECTOR_ID_EN undefined:
//   - No vector logic is built.
//   - VECTOR_ID is unmapped: RD_HIT=0, RD_DATA=0.
// TESTING
//  Reset, then IRQ[3] rises with mask=8'h08 -> STATUS=8'h08; INTV high 4 CLK after the edge, for 2 CLK.
//  mask=0, IRQ[0] pulses -> STATUS=8'h01, INTV stays 0; then write mask 8'h01 -> INTV pulses, FSM ends in WAIT.
//  In WAIT, write CLEAR_ID 8'h01 -> INTV stays 0, FSM is IDLE next cycle, STATUS=8'h00.
//  IRQ[2] edge in the same cycle as CLEAR_ID write of 8'h04 -> STATUS bit 2 stays 1.
//  REARM_CYCLES=16, pending never cleared -> second INTV pulse starts 16 CLK after the first ends.
//  VECTOR_EN: pending=8'h24, mask=8'hFF -> VECTOR read=8'h82; RESET_N low during ASSERT -> INTV=0 at once, all regs 0.

Source files
------------

// File: rtl/rat_intr_ctrl_if.sv
// MCU port bus between RAT_MCU (master) and the interrupt controller (slave).
// Write side is PORT_ID/OUT_PORT/IO_STRB; the readback pair feeds the wrapper input mux.
interface rat_intr_ctrl_if;
   logic [7:0] PORT_ID;
   logic [7:0] OUT_PORT;
   logic       IO_STRB;
   logic [7:0] RD_DATA;
   logic       RD_HIT;

   modport master (
      output PORT_ID,
      output OUT_PORT,
      output IO_STRB,
      input  RD_DATA,
      input  RD_HIT
   );

   modport slave (
      input  PORT_ID,
      input  OUT_PORT,
      input  IO_STRB,
      output RD_DATA,
      output RD_HIT
   );
endinterface

// File: rtl/rat_intr_ctrl.sv
// Interrupt controller for RAT_MCU: sync/edge-detect IRQs, pending+mask registers, INTV sequencer.
// Optional vector readback at VECTOR_ID is built only when RAT_INTR_VECTOR_ID_EN is defined.
module rat_intr_ctrl #(
   parameter int unsigned NUM_SRC      = 8,
   parameter int unsigned INTV_HOLD    = 2,
   parameter int unsigned REARM_CYCLES = 1024,
   parameter logic [7:0]  MASK_ID      = 8'h80,
   parameter logic [7:0]  STATUS_ID    = 8'h81,
   parameter logic [7:0]  CLEAR_ID     = 8'h82,
   parameter logic [7:0]  VECTOR_ID    = 8'h83
) (
   input  logic               CLK,
   input  logic               RESET_N,
   input  logic [NUM_SRC-1:0] IRQ,
   output logic               INTV,
   rat_intr_ctrl_if.slave     bus
);

   localparam int unsigned HOLD_W     = 4;
   localparam int unsigned REARM_W    = (REARM_CYCLES > 2) ? $clog2(REARM_CYCLES) : 1;
   localparam int unsigned REARM_LAST = (REARM_CYCLES == 0) ? 0 : REARM_CYCLES - 1;
   localparam int unsigned HOLD_LAST  = (INTV_HOLD == 0) ? 0 : INTV_HOLD - 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ASSERT = 2'd1,
      S_WAIT   = 2'd2
   } state_t;

   state_t               state, state_d;
   logic [HOLD_W-1:0]    hold_cnt, hold_cnt_d;
   logic [REARM_W-1:0]   rearm_cnt, rearm_cnt_d;

   logic [NUM_SRC-1:0]   irq_s1, irq_s2, irq_prev;
   logic [NUM_SRC-1:0]   rise;
   logic [NUM_SRC-1:0]   mask, pending;
   logic [NUM_SRC-1:0]   clr_bits;
   logic [NUM_SRC-1:0]   act_vec;
   logic                 active;
   logic                 wr_mask, wr_clear;

   // Two-flop synchronizer plus previous-value flop for rising-edge detection
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         irq_s1   <= '0;
         irq_s2   <= '0;
         irq_prev <= '0;
      end else begin
         irq_s1   <= IRQ;
         irq_s2   <= irq_s1;
         irq_prev <= irq_s2;
      end
   end

   assign rise     = irq_s2 & ~irq_prev;
   assign wr_mask  = bus.IO_STRB && (bus.PORT_ID == MASK_ID);
   assign wr_clear = bus.IO_STRB && (bus.PORT_ID == CLEAR_ID);
   assign clr_bits = wr_clear ? bus.OUT_PORT[NUM_SRC-1:0] : '0;
   assign act_vec  = pending & mask;
   assign active   = |act_vec;

   // Mask and pending; a new edge beats a simultaneous W1C of the same bit
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         mask    <= '0;
         pending <= '0;
      end else begin
         if (wr_mask) begin
            mask <= bus.OUT_PORT[NUM_SRC-1:0];
         end
         pending <= (pending & ~clr_bits) | rise;
      end
   end

   // Combinational readback
   always_comb begin
      bus.RD_DATA = 8'h00;
      bus.RD_HIT  = 1'b0;
      if (bus.PORT_ID == MASK_ID) begin
         bus.RD_DATA = 8'(mask);
         bus.RD_HIT  = 1'b1;
      end else if (bus.PORT_ID == STATUS_ID) begin
         bus.RD_DATA = 8'(pending);
         bus.RD_HIT  = 1'b1;
      end else if (bus.PORT_ID == VECTOR_ID) begin
`ifdef RAT_INTR_VECTOR_ID_EN
         bus.RD_HIT = 1'b1;
         for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (act_vec[i]) begin
               bus.RD_DATA = {1'b1, 4'b0000, 3'(i)};
            end
         end
`else
         // Vector register not built: ID reads as unmapped
         bus.RD_DATA = 8'h00;
         bus.RD_HIT  = 1'b0;
`endif
      end
   end

   // State register, counters and registered INTV
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state     <= S_IDLE;
         hold_cnt  <= '0;
         rearm_cnt <= '0;
         INTV      <= 1'b0;
      end else begin
         state     <= state_d;
         hold_cnt  <= hold_cnt_d;
         rearm_cnt <= rearm_cnt_d;
         INTV      <= (state_d == S_ASSERT);
      end
   end

   // Next-state: ASSERT holds for INTV_HOLD cycles, WAIT re-arms after REARM_CYCLES
   always_comb begin
      state_d     = state;
      hold_cnt_d  = hold_cnt;
      rearm_cnt_d = rearm_cnt;
      case (state)
         S_IDLE: begin
            if (active) begin
               state_d    = S_ASSERT;
               hold_cnt_d = '0;
            end
         end
         S_ASSERT: begin
            if (hold_cnt == HOLD_W'(HOLD_LAST)) begin
               state_d     = S_WAIT;
               rearm_cnt_d = '0;
            end else begin
               hold_cnt_d = hold_cnt + HOLD_W'(1);
            end
         end
         S_WAIT: begin
            if (!active) begin
               state_d = S_IDLE;
            end else if ((REARM_CYCLES != 0) && (rearm_cnt == REARM_W'(REARM_LAST))) begin
               state_d    = S_ASSERT;
               hold_cnt_d = '0;
            end else begin
               rearm_cnt_d = rearm_cnt + REARM_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_rat_intr_ctrl.sv
// Directed bench for rat_intr_ctrl (REARM_CYCLES=16); vector checks follow RAT_INTR_VECTOR_ID_EN.
module tb_rat_intr_ctrl;

   localparam logic [7:0] MASK_ID   = 8'h80;
   localparam logic [7:0] STATUS_ID = 8'h81;
   localparam logic [7:0] CLEAR_ID  = 8'h82;
   localparam logic [7:0] VECTOR_ID = 8'h83;

   logic       CLK;
   logic       RESET_N;
   logic [7:0] IRQ;
   logic       INTV;
   int         n_chk;
   int         n_pass;
   logic [7:0] rdat;
   logic       rhit;

   rat_intr_ctrl_if bus();

   rat_intr_ctrl #(
      .NUM_SRC      (8),
      .INTV_HOLD    (2),
      .REARM_CYCLES (16)
   ) dut (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .IRQ     (IRQ),
      .INTV    (INTV),
      .bus     (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      else n_pass++;
   endtask

   // Called at a negedge; commits on the following posedge, returns at the next negedge
   task automatic wr(input logic [7:0] id, input logic [7:0] data);
      bus.PORT_ID  = id;
      bus.OUT_PORT = data;
      bus.IO_STRB  = 1'b1;
      @(negedge CLK);
      bus.IO_STRB  = 1'b0;
   endtask

   task automatic rd(input logic [7:0] id, output logic [7:0] d, output logic h);
      bus.PORT_ID = id;
      #1;
      d = bus.RD_DATA;
      h = bus.RD_HIT;
   endtask

   initial begin
      n_chk = 0;
      n_pass = 0;
      RESET_N = 1'b0;
      IRQ = 8'h00;
      bus.PORT_ID = 8'h00;
      bus.OUT_PORT = 8'h00;
      bus.IO_STRB = 1'b0;
      repeat (3) @(negedge CLK);
      RESET_N = 1'b1;

      // Reset state
      check("rst_intv", 32'(INTV), 32'h0);
      rd(STATUS_ID, rdat, rhit);
      check("rst_status", 32'(rdat), 32'h00);
      check("rst_status_hit", 32'(rhit), 32'h1);
      rd(MASK_ID, rdat, rhit);
      check("rst_mask", 32'(rdat), 32'h00);
      rd(8'h55, rdat, rhit);
      check("unmapped_data", 32'(rdat), 32'h00);
      check("unmapped_hit", 32'(rhit), 32'h0);

      // IRQ[3] with mask 08: latency 4, 2-cycle pulse, re-arm 16 cycles after the pulse ends
      @(negedge CLK);
      wr(MASK_ID, 8'h08);
      IRQ[3] = 1'b1;
      for (int k = 1; k <= 24; k++) begin
         @(negedge CLK);
         check($sformatf("irq3_intv_k%0d", k), 32'(INTV),
               32'((k == 4) || (k == 5) || (k == 22) || (k == 23)));
         if (k == 2) begin
            rd(STATUS_ID, rdat, rhit);
            check("irq3_status_early", 32'(rdat), 32'h00);
         end
         if (k == 3) begin
            rd(STATUS_ID, rdat, rhit);
            check("irq3_status", 32'(rdat), 32'h08);
         end
      end
      // Clear while in WAIT: no more pulses
      wr(CLEAR_ID, 8'h08);
      rd(STATUS_ID, rdat, rhit);
      check("clr3_status", 32'(rdat), 32'h00);
      for (int k = 0; k < 20; k++) begin
         @(negedge CLK);
         check($sformatf("clr3_intv_%0d", k), 32'(INTV), 32'h0);
      end
      IRQ[3] = 1'b0;

      // Masked IRQ[0] pulse: pending but no INTV; unmask releases it
      wr(MASK_ID, 8'h00);
      IRQ[0] = 1'b1;
      repeat (2) @(negedge CLK);
      IRQ[0] = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK);
         check($sformatf("masked_intv_%0d", k), 32'(INTV), 32'h0);
      end
      rd(STATUS_ID, rdat, rhit);
      check("masked_status", 32'(rdat), 32'h01);
      @(negedge CLK);
      wr(MASK_ID, 8'h01);
      check("unmask_intv0", 32'(INTV), 32'h0);
      @(negedge CLK);
      check("unmask_intv1", 32'(INTV), 32'h1);
      @(negedge CLK);
      check("unmask_intv2", 32'(INTV), 32'h1);
      @(negedge CLK);
      check("unmask_intv3", 32'(INTV), 32'h0);
      // Clear in WAIT returns to IDLE: a fresh IRQ[0] pulses after the normal latency
      wr(CLEAR_ID, 8'h01);
      rd(STATUS_ID, rdat, rhit);
      check("clr0_status", 32'(rdat), 32'h00);
      check("clr0_intv", 32'(INTV), 32'h0);
      @(negedge CLK);
      IRQ[0] = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge CLK);
         check($sformatf("idle_again_k%0d", k), 32'(INTV), 32'((k == 4) || (k == 5)));
      end
      IRQ[0] = 1'b0;
      wr(CLEAR_ID, 8'h01);
      repeat (3) @(negedge CLK);

      // IRQ[2] edge lands in the same cycle as a CLEAR of bit 2: set wins
      rd(STATUS_ID, rdat, rhit);
      check("pre_race_status", 32'(rdat), 32'h00);
      @(negedge CLK);
      IRQ[2] = 1'b1;
      repeat (2) @(negedge CLK);
      wr(CLEAR_ID, 8'h04);
      rd(STATUS_ID, rdat, rhit);
      check("race_status", 32'(rdat), 32'h04);
      @(negedge CLK);
      IRQ[2] = 1'b0;
      wr(CLEAR_ID, 8'h04);
      rd(STATUS_ID, rdat, rhit);
      check("race_cleared", 32'(rdat), 32'h00);
      // Writes to other IDs are ignored
      @(negedge CLK);
      wr(8'h90, 8'hFF);
      rd(MASK_ID, rdat, rhit);
      check("other_id_mask", 32'(rdat), 32'h01);
      check("intv_quiet", 32'(INTV), 32'h0);

      // pending=24, mask=FF: vector read, then reset in the middle of ASSERT
      @(negedge CLK);
      wr(MASK_ID, 8'hFF);
      IRQ = 8'h24;
      repeat (3) @(negedge CLK);
      rd(STATUS_ID, rdat, rhit);
      check("vec_status", 32'(rdat), 32'h24);
      rd(VECTOR_ID, rdat, rhit);
`ifdef RAT_INTR_VECTOR_ID_EN
      check("vec_data", 32'(rdat), 32'h82);
      check("vec_hit", 32'(rhit), 32'h1);
`else
      check("vec_data", 32'(rdat), 32'h00);
      check("vec_hit", 32'(rhit), 32'h0);
`endif
      @(negedge CLK);
      check("pre_rst_intv", 32'(INTV), 32'h1);
      RESET_N = 1'b0;
      #1;
      check("rst_mid_intv", 32'(INTV), 32'h0);
      rd(STATUS_ID, rdat, rhit);
      check("rst_mid_status", 32'(rdat), 32'h00);
      rd(MASK_ID, rdat, rhit);
      check("rst_mid_mask", 32'(rdat), 32'h00);
      IRQ = 8'h00;
      repeat (2) @(negedge CLK);
      RESET_N = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge CLK);
         check($sformatf("post_rst_intv_%0d", k), 32'(INTV), 32'h0);
      end
      rd(STATUS_ID, rdat, rhit);
      check("post_rst_status", 32'(rdat), 32'h00);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
